// File: rtl/la_capture.sv
// Logic-analyser capture: synchronised 8-channel sampling into a circular
// buffer, masked-pattern trigger with pre-trigger depth, oldest-first readout.
module la_capture #(
  parameter int AW    = 8,
  parameter int DIV_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       din,
  input  logic             arm,
  input  logic             abort,
  input  logic [DIV_W-1:0] div_max,
  input  logic [7:0]       trig_pattern,
  input  logic [7:0]       trig_mask,
  input  logic [AW-1:0]    pre_cnt,
  input  logic             rd_req,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             rd_last,
  output logic             busy,
  output logic             triggered,
  output logic             done
);

  typedef enum logic [2:0] {IDLE, PRE, WAIT_TRIG, POST, DONE} state_t;

  localparam logic [AW:0] DEPTH_W = {1'b1, {AW{1'b0}}};

  state_t           state, state_next;
  logic [7:0]       sync1, s_din;
  logic [DIV_W-1:0] div_cnt;
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_cnt;
  logic [AW:0]      smp_cnt, smp_cnt_next;
  logic [AW:0]      post_target;
  logic [7:0]       ch_hit;
  logic [7:0]       mem_q;
  logic [7:0]       mem [0:(1<<AW)-1];
  logic             running, tick, match, accept_arm;
  logic             wr_en, rd_en, trig_set;

  assign running     = (state == PRE) || (state == WAIT_TRIG) || (state == POST);
  assign tick        = running && (div_cnt == div_max);
  assign post_target = DEPTH_W - {1'b0, pre_cnt};
  assign accept_arm  = (state == IDLE) && arm && !abort;

  genvar gi;
  for (gi = 0; gi < 8; gi++) begin : g_match
    assign ch_hit[gi] = ~trig_mask[gi] | (s_din[gi] ~^ trig_pattern[gi]);
  end
  assign match = &ch_hit;

  always_comb begin
    state_next   = state;
    smp_cnt_next = smp_cnt;
    wr_en        = 1'b0;
    rd_en        = 1'b0;
    trig_set     = 1'b0;
    case (state)
      IDLE: begin
        if (arm) begin
          state_next   = PRE;
          smp_cnt_next = '0;
        end
      end
      PRE: begin
        if (pre_cnt == '0) begin
          state_next = WAIT_TRIG;
        end else if (tick) begin
          wr_en        = 1'b1;
          smp_cnt_next = smp_cnt + 1'b1;
          if (smp_cnt_next == {1'b0, pre_cnt}) begin
            state_next   = WAIT_TRIG;
            smp_cnt_next = '0;
          end
        end
      end
      WAIT_TRIG: begin
        if (tick) begin
          wr_en = 1'b1;
          if (match) begin
            // The trigger sample itself is the first post-trigger sample.
            trig_set     = 1'b1;
            smp_cnt_next = {{AW{1'b0}}, 1'b1};
            state_next   = (post_target == {{AW{1'b0}}, 1'b1}) ? DONE : POST;
          end
        end
      end
      POST: begin
        if (tick) begin
          wr_en        = 1'b1;
          smp_cnt_next = smp_cnt + 1'b1;
          if (smp_cnt_next == post_target) state_next = DONE;
        end
      end
      DONE: begin
        if (rd_req) begin
          rd_en = 1'b1;
          if (rd_cnt == '1) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (abort) begin
      state_next = IDLE;
      wr_en      = 1'b0;
      rd_en      = 1'b0;
      trig_set   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sync1     <= '0;
      s_din     <= '0;
      div_cnt   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rd_cnt    <= '0;
      smp_cnt   <= '0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      triggered <= 1'b0;
    end else begin
      sync1   <= din;
      s_din   <= sync1;
      state   <= state_next;
      smp_cnt <= smp_cnt_next;

      if (!running || tick) div_cnt <= '0;
      else                  div_cnt <= div_cnt + 1'b1;

      if (accept_arm) wr_ptr <= '0;
      else if (wr_en) wr_ptr <= wr_ptr + 1'b1;

      // DONE is always entered on a write edge, so the oldest sample sits
      // one past the slot being written now.
      if (state != DONE && state_next == DONE) begin
        rd_ptr <= wr_ptr + 1'b1;
        rd_cnt <= '0;
      end else if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
        rd_cnt <= rd_cnt + 1'b1;
      end

      rd_valid <= rd_en;
      rd_last  <= rd_en && (rd_cnt == '1);

      if (trig_set)                 triggered <= 1'b1;
      else if (state_next == IDLE)  triggered <= 1'b0;
      else if (accept_arm)          triggered <= 1'b0;
    end
  end

  // Buffer RAM: no reset so it maps onto block memory.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= s_din;
    if (rd_en) mem_q <= mem[rd_ptr];
  end

  assign rd_data = rd_valid ? mem_q : 8'h00;
  assign busy    = running;
  assign done    = (state == DONE);

endmodule

// File: tb/tb_la_capture.sv
// Bench for la_capture: randomized captures against a tick-indexed model of
// the sampled bus history; readout words checked through a scoreboard queue.
module tb_la_capture;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  din = 8'h00;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] div_max = '0;
  logic [7:0]  trig_pattern = 8'h00;
  logic [7:0]  trig_mask = 8'h00;
  logic [7:0]  pre_cnt = 8'h00;
  logic        rd_req = 1'b0;
  logic [7:0]  rd_data;
  logic        rd_valid, rd_last, busy, triggered, done;

  la_capture #(.AW(8), .DIV_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .arm(arm), .abort(abort),
    .div_max(div_max), .trig_pattern(trig_pattern), .trig_mask(trig_mask),
    .pre_cnt(pre_cnt), .rd_req(rd_req), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_last(rd_last), .busy(busy),
    .triggered(triggered), .done(done)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  logic [7:0] hist[$];
  logic [7:0] exp_data[$];
  logic       exp_last[$];
  int         din_mode = 0;
  logic [7:0] din_const = 8'h00;
  logic [7:0] seq [8] = '{8'h05, 8'h82, 8'h41, 8'hA0, 8'h50, 8'h28, 8'h14, 8'h0A};

  // hist[e] is the din value seen at posedge number e.
  always @(posedge clk) begin
    hist.push_back(din);
    cyc <= cyc + 1;
  end

  initial begin
    forever begin
      @(negedge clk);
      case (din_mode)
        0:       din = din_const;
        1:       din = 8'($urandom);
        default: din = seq[cyc % 8];
      endcase
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial begin
    logic [7:0] ed;
    logic       el;
    forever begin
      @(negedge clk);
      if (rst_n && rd_valid) begin
        if (exp_data.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rd_unexpected: got rd_valid data %02h expected none", rd_data);
        end else begin
          ed = exp_data.pop_front();
          el = exp_last.pop_front();
          chk("rd_data", rd_data, ed);
          chk("rd_last", rd_last, el);
        end
      end
    end
  end

  // Value stored by tick k of a capture armed at edge a: s_din lags din by two edges.
  function automatic logic [7:0] smp(input int a, input int d, input int k);
    return hist[a + (d + 1) * k - 2];
  endfunction

  task automatic arm_capture(input int d, input int p, input logic [7:0] pat,
                             input logic [7:0] msk, output int a);
    @(negedge clk);
    div_max = 32'(d); pre_cnt = 8'(p); trig_pattern = pat; trig_mask = msk;
    @(negedge clk);
    a = cyc;
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit poke_post, output bit ok);
    bit fired = 0;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin ok = 1; break; end
      if (poke_post && triggered && !fired) begin
        fired = 1;
        arm = 1'b1; rd_req = 1'b1;
        @(negedge clk);
        arm = 1'b0; rd_req = 1'b0;
        chk("post_rd_valid", rd_valid, 0);
        chk("post_busy", busy, 1);
      end else begin
        @(negedge clk);
      end
    end
    if (!ok) begin
      chk("done_timeout", 0, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
  endtask

  // Spec-level model: find the trigger tick, check DONE timing, queue the window.
  task automatic check_and_queue(input int a, input int d, input int p,
                                 input logic [7:0] pat, input logic [7:0] msk);
    int done_edge = cyc - 1;
    int kmin = (p > 0) ? p + 1 : ((d == 0) ? 2 : 1);
    int t = -1;
    for (int k = kmin; a + (d + 1) * k <= done_edge; k++) begin
      if (((smp(a, d, k) ^ pat) & msk) == 8'h00) begin t = k; break; end
    end
    if (t < 0) begin
      chk("trigger_found", 0, 1);
      return;
    end
    chk("done_time", done_edge, a + (d + 1) * (t + DEPTH - p - 1));
    chk("triggered_in_done", triggered, 1);
    chk("busy_in_done", busy, 0);
    for (int i = 0; i < DEPTH; i++) begin
      exp_data.push_back(smp(a, d, t - p + i));
      exp_last.push_back(i == DEPTH - 1);
    end
  endtask

  task automatic read_all();
    rd_req = 1'b1;
    repeat (DEPTH) @(negedge clk);
    rd_req = 1'b0;
    @(negedge clk);
    chk("queue_drained", exp_data.size(), 0);
    chk("idle_after_read", {busy, done, triggered}, 0);
  endtask

  task automatic full_capture(input int d, input int p, input logic [7:0] pat,
                              input logic [7:0] msk, input bit poke_post);
    int a;
    bit ok;
    arm_capture(d, p, pat, msk, a);
    wait_done((d + 1) * 3000 + 100, poke_post, ok);
    if (ok) begin
      check_and_queue(a, d, p, pat, msk);
      read_all();
    end
  endtask

  task automatic chk_outs_zero(input string nm);
    chk(nm, {rd_data, rd_valid, rd_last, busy, triggered, done}, 0);
  endtask

  initial begin
    int a;
    bit ok;
    #1 rst_n = 1'b0;
    #1 chk_outs_zero("reset_outputs");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // rd_req in IDLE is ignored
    rd_req = 1'b1;
    repeat (4) begin @(negedge clk); chk("idle_rd_valid", rd_valid, 0); end
    rd_req = 1'b0;

    // T1: shifting pattern, exact trigger value
    din_mode = 2;
    full_capture(0, 4, 8'h50, 8'hFF, 0);

    // T2: mask 0, no pre-trigger samples
    din_mode = 1;
    full_capture(0, 0, 8'($urandom), 8'h00, 0);

    // T3: slow sample rate, constant bus
    din_mode = 0; din_const = 8'hA5;
    full_capture(49, 0, 8'hA5, 8'hFF, 0);

    // T4: never-matching trigger, then abort; arm+abort in IDLE stays idle
    din_const = 8'h00;
    arm_capture(0, 5, 8'hFF, 8'hFF, a);
    repeat (600) @(negedge clk);
    chk("t4_busy", busy, 1);
    chk("t4_done", done, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t4_abort_flags", {busy, triggered, done}, 0);
    arm = 1'b1; abort = 1'b1;
    @(negedge clk);
    arm = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("arm_abort_idle", busy, 0);
    din_mode = 1;
    full_capture(0, 7, 8'($urandom), 8'h03, 0);

    // T5: arm and rd_req during POST are ignored
    full_capture(1, 3, 8'($urandom), 8'h00, 1);

    // Randomized captures including pre_cnt boundaries
    full_capture($urandom_range(0, 3), 255, 8'($urandom), 8'($urandom) & 8'($urandom), 0);
    full_capture($urandom_range(0, 3), 1, 8'($urandom), 8'($urandom) & 8'($urandom), 0);
    full_capture($urandom_range(0, 3), $urandom_range(0, 255), 8'($urandom),
                 8'($urandom) & 8'($urandom), 0);

    // T6a: reset mid-POST
    arm_capture(0, 10, 8'h00, 8'h00, a);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (triggered) begin ok = 1; break; end
      @(negedge clk);
    end
    chk("t6_triggered_seen", ok, 1);
    repeat (20) @(negedge clk);
    chk("t6_in_post", busy, 1);
    #2 rst_n = 1'b0;
    #1 chk_outs_zero("t6_reset_post");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // T6b: reset mid-readout, no partial readout afterwards
    arm_capture(0, 20, 8'($urandom), 8'h01, a);
    wait_done(3000, 0, ok);
    if (ok) begin
      check_and_queue(a, 0, 20, trig_pattern, trig_mask);
      rd_req = 1'b1;
      repeat (100) @(negedge clk);
      #2 rst_n = 1'b0;
      exp_data.delete();
      exp_last.delete();
      rd_req = 1'b0;
      #1 chk_outs_zero("t6_reset_read");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      rd_req = 1'b1;
      repeat (3) begin @(negedge clk); chk("t6_no_partial", rd_valid, 0); end
      rd_req = 1'b0;
    end
    full_capture(2, 64, 8'($urandom), 8'($urandom) & 8'($urandom), 0);

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
